// File: rtl/mine_field_placer.sv
// Mine placer: clears the board, marks a safe zone around the root,
// then drops mines by rejection sampling a free-running LFSR.
module mine_field_placer #(
   parameter int          ROWS      = 8,
   parameter int          COLS      = 8,
   parameter int          TILES     = ROWS * COLS,
   parameter int          IDX_W     = (TILES > 1) ? $clog2(TILES) : 1,
   parameter int          ROW_W     = (ROWS > 1) ? $clog2(ROWS) : 1,
   parameter int          COL_W     = (COLS > 1) ? $clog2(COLS) : 1,
   parameter int          CNT_W     = $clog2(TILES + 1),
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [ROW_W-1:0] root_row,
   input  logic [COL_W-1:0] root_col,
   input  logic [CNT_W-1:0] num_mines,
   input  logic             safe_mode,
   output logic [TILES-1:0] mine_map,
   output logic [CNT_W-1:0] placed,
   output logic             busy,
   output logic             done,
   output logic             err
);

   localparam logic [ROW_W:0]   ROWS_U  = ROWS[ROW_W:0];
   localparam logic [COL_W:0]   COLS_U  = COLS[COL_W:0];
   localparam logic [IDX_W:0]   TILES_I = TILES[IDX_W:0];
   localparam logic [IDX_W:0]   COLS_I  = COLS[IDX_W:0];
   localparam logic [CNT_W-1:0] TILES_C = TILES[CNT_W-1:0];

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_SAFE, S_PLACE, S_DONE
   } state_t;

   state_t           state_q;
   logic [15:0]      lfsr_q;
   logic [TILES-1:0] map_q, safe_q;
   logic [CNT_W-1:0] placed_q, safe_cnt_q, num_q;
   logic [3:0]       step_q;
   logic [ROW_W-1:0] row_q;
   logic [COL_W-1:0] col_q;
   logic             mode_q, busy_q, done_q, err_q;

   logic [1:0]       dr, dc;
   logic [ROW_W+1:0] r_s;
   logic [COL_W+1:0] c_s;
   logic [IDX_W:0]   r_u, c_u, sidx_d;
   logic             s_ok, last_d, over_d, accept_d;
   logic [CNT_W-1:0] safe_nx_d;
   logic [IDX_W-1:0] cand;

   // Neighbour offsets in 2-bit two's complement, root first
   always_comb begin
      dr = 2'b00;
      dc = 2'b00;
      case (step_q)
         4'd1:    begin dr = 2'b11; dc = 2'b11; end
         4'd2:    begin dr = 2'b11; dc = 2'b00; end
         4'd3:    begin dr = 2'b11; dc = 2'b01; end
         4'd4:    begin dr = 2'b00; dc = 2'b11; end
         4'd5:    begin dr = 2'b00; dc = 2'b01; end
         4'd6:    begin dr = 2'b01; dc = 2'b11; end
         4'd7:    begin dr = 2'b01; dc = 2'b00; end
         4'd8:    begin dr = 2'b01; dc = 2'b01; end
         default: begin dr = 2'b00; dc = 2'b00; end
      endcase
   end

   always_comb begin
      r_s = {2'b00, row_q} + {{ROW_W{dr[1]}}, dr};
      c_s = {2'b00, col_q} + {{COL_W{dc[1]}}, dc};
      r_u = '0;
      c_u = '0;
      r_u[ROW_W-1:0] = r_s[ROW_W-1:0];
      c_u[COL_W-1:0] = c_s[COL_W-1:0];
      sidx_d = r_u * COLS_I + c_u;
      s_ok = !r_s[ROW_W+1] && (r_s[ROW_W:0] < ROWS_U)
          && !c_s[COL_W+1] && (c_s[COL_W:0] < COLS_U)
          && (sidx_d < TILES_I);
      safe_nx_d = safe_cnt_q + {{(CNT_W-1){1'b0}}, s_ok};
      last_d = !mode_q || (step_q == 4'd8);
      over_d = num_q > (TILES_C - safe_nx_d);
      cand = lfsr_q[IDX_W-1:0];
      accept_d = ({1'b0, cand} < TILES_I)
              && !safe_q[cand] && !map_q[cand];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         lfsr_q     <= LFSR_SEED;
         map_q      <= '0;
         safe_q     <= '0;
         placed_q   <= '0;
         safe_cnt_q <= '0;
         num_q      <= '0;
         step_q     <= '0;
         row_q      <= '0;
         col_q      <= '0;
         mode_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         lfsr_q <= {lfsr_q[14:0],
                    lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
         if (abort) begin
            state_q  <= S_IDLE;
            map_q    <= '0;
            placed_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
         end else begin
            case (state_q)
               S_IDLE, S_DONE: begin
                  if (start) begin
                     state_q    <= S_CLEAR;
                     row_q      <= root_row;
                     col_q      <= root_col;
                     num_q      <= num_mines;
                     mode_q     <= safe_mode;
                     map_q      <= '0;
                     safe_q     <= '0;
                     placed_q   <= '0;
                     safe_cnt_q <= '0;
                     busy_q     <= 1'b1;
                     done_q     <= 1'b0;
                     err_q      <= 1'b0;
                  end
               end
               S_CLEAR: begin
                  if ({1'b0, row_q} >= ROWS_U || {1'b0, col_q} >= COLS_U) begin
                     state_q <= S_DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     err_q   <= 1'b1;
                  end else begin
                     state_q <= S_SAFE;
                     step_q  <= '0;
                  end
               end
               S_SAFE: begin
                  if (s_ok) safe_q[sidx_d[IDX_W-1:0]] <= 1'b1;
                  safe_cnt_q <= safe_nx_d;
                  step_q     <= step_q + 4'd1;
                  if (last_d) begin
                     if (over_d) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                     end else begin
                        state_q <= S_PLACE;
                     end
                  end
               end
               S_PLACE: begin
                  if (placed_q == num_q) begin
                     state_q <= S_DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else if (accept_d) begin
                     map_q[cand] <= 1'b1;
                     placed_q    <= placed_q + 1'b1;
                  end
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign mine_map = map_q;
   assign placed   = placed_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign err      = err_q;

endmodule

// File: tb/tb_mine_field_placer.sv
// Directed bench for mine_field_placer: 8x8 and 5x7 boards,
// safe zones, capacity/range errors, abort, reset and restart.
module tb_mine_field_placer;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        a_start, a_abort, a_mode;
   logic [2:0]  a_row, a_col;
   logic [6:0]  a_num, a_placed;
   logic [63:0] a_map;
   logic        a_busy, a_done, a_err;

   logic        b_start, b_abort, b_mode;
   logic [2:0]  b_row, b_col;
   logic [5:0]  b_num, b_placed;
   logic [34:0] b_map;
   logic        b_busy, b_done, b_err;

   int n_cmp = 0;
   int n_bad = 0;

   mine_field_placer u_a (
      .clk(clk), .rst(rst), .start(a_start), .abort(a_abort),
      .root_row(a_row), .root_col(a_col), .num_mines(a_num),
      .safe_mode(a_mode), .mine_map(a_map), .placed(a_placed),
      .busy(a_busy), .done(a_done), .err(a_err)
   );

   mine_field_placer #(.ROWS(5), .COLS(7)) u_b (
      .clk(clk), .rst(rst), .start(b_start), .abort(b_abort),
      .root_row(b_row), .root_col(b_col), .num_mines(b_num),
      .safe_mode(b_mode), .mine_map(b_map), .placed(b_placed),
      .busy(b_busy), .done(b_done), .err(b_err)
   );

   task automatic go_a(input int r, input int c, input int m, input int n);
      @(negedge clk);
      a_row = 3'(r); a_col = 3'(c); a_mode = m[0]; a_num = 7'(n);
      a_start = 1'b1;
      @(negedge clk);
      a_start = 1'b0;
   endtask

   task automatic go_b(input int r, input int c, input int m, input int n);
      @(negedge clk);
      b_row = 3'(r); b_col = 3'(c); b_mode = m[0]; b_num = 6'(n);
      b_start = 1'b1;
      @(negedge clk);
      b_start = 1'b0;
   endtask

   task automatic wait_a(output int cyc);
      cyc = 1;
      while (a_done !== 1'b1 && cyc < 40000) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic wait_b(output int cyc);
      cyc = 1;
      while (b_done !== 1'b1 && cyc < 40000) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      a_start = 0; a_abort = 0; a_mode = 0; a_row = 0; a_col = 0; a_num = 0;
      b_start = 0; b_abort = 0; b_mode = 0; b_row = 0; b_col = 0; b_num = 0;
      repeat (3) @(negedge clk);
      n_cmp++; if (a_map !== 64'h0) begin n_bad++;
         $display("FAIL reset_map got %h want 0", a_map); end
      n_cmp++; if (a_placed !== 7'd0) begin n_bad++;
         $display("FAIL reset_placed got %0d want 0", a_placed); end
      n_cmp++; if ({a_busy, a_done, a_err} !== 3'b000) begin n_bad++;
         $display("FAIL reset_flags got %b want 000", {a_busy, a_done, a_err}); end
      n_cmp++; if ({b_map, b_busy, b_done, b_err} !== 38'h0) begin n_bad++;
         $display("FAIL reset_b got %h want 0", {b_map, b_busy, b_done, b_err}); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_corner;
      int cyc;
      go_a(0, 0, 1, 10);
      wait_a(cyc);
      n_cmp++; if ({a_done, a_err} !== 2'b10) begin n_bad++;
         $display("FAIL corner_done got %b want 10", {a_done, a_err}); end
      n_cmp++; if (a_placed !== 7'd10) begin n_bad++;
         $display("FAIL corner_placed got %0d want 10", a_placed); end
      n_cmp++; if ($countones(a_map) !== 10) begin n_bad++;
         $display("FAIL corner_pop got %0d want 10", $countones(a_map)); end
      n_cmp++; if ((a_map & 64'h303) !== 64'h0) begin n_bad++;
         $display("FAIL corner_safe got %h want 0", a_map & 64'h303); end
      n_cmp++; if ((cyc >= 21) !== 1'b1) begin n_bad++;
         $display("FAIL corner_latency got %0d want >=21", cyc); end
   endtask

   task automatic test_restart;
      int cyc;
      go_a(7, 7, 1, 10);
      n_cmp++; if ({a_done, a_map} !== 65'h0) begin n_bad++;
         $display("FAIL restart_clear got %h want 0", {a_done, a_map}); end
      wait_a(cyc);
      n_cmp++; if ({a_done, a_err, a_placed} !== {2'b10, 7'd10}) begin n_bad++;
         $display("FAIL restart_done got %h want %h",
                  {a_done, a_err, a_placed}, {2'b10, 7'd10}); end
      n_cmp++; if ((a_map & 64'hC0C0_0000_0000_0000) !== 64'h0
                   || $countones(a_map) !== 10) begin n_bad++;
         $display("FAIL restart_map got %h want 10 mines off C0C0..", a_map); end
   endtask

   task automatic test_full_board;
      int cyc;
      go_a(3, 4, 1, 55);
      wait_a(cyc);
      n_cmp++; if ({a_done, a_err} !== 2'b10) begin n_bad++;
         $display("FAIL full_done got %b want 10", {a_done, a_err}); end
      n_cmp++; if (a_map !== 64'hFFFF_FFC7_C7C7_FFFF) begin n_bad++;
         $display("FAIL full_map got %h want ffffffc7c7c7ffff", a_map); end
      n_cmp++; if (a_placed !== 7'd55) begin n_bad++;
         $display("FAIL full_placed got %0d want 55", a_placed); end
   endtask

   task automatic test_capacity;
      int cyc;
      go_a(3, 4, 1, 56);
      wait_a(cyc);
      n_cmp++; if ({a_done, a_err, a_busy} !== 3'b110) begin n_bad++;
         $display("FAIL cap56_flags got %b want 110", {a_done, a_err, a_busy}); end
      n_cmp++; if ({a_map, a_placed} !== 71'h0) begin n_bad++;
         $display("FAIL cap56_map got %h want 0", {a_map, a_placed}); end
      go_a(0, 0, 1, 61);
      wait_a(cyc);
      n_cmp++; if ({a_done, a_err} !== 2'b11) begin n_bad++;
         $display("FAIL cap61_err got %b want 11", {a_done, a_err}); end
      go_a(0, 0, 1, 60);
      wait_a(cyc);
      n_cmp++; if ({a_done, a_err, a_map} !== {2'b10, 64'hFFFF_FFFF_FFFF_FCFC}) begin
         n_bad++;
         $display("FAIL cap60_map got %h want fffffffffffffcfc err 0", a_map); end
   endtask

   task automatic test_start_ignored;
      int cyc;
      go_a(3, 4, 1, 55);
      repeat (14) @(negedge clk);
      a_row = 3'd0; a_col = 3'd0; a_num = 7'd10; a_start = 1'b1;
      @(negedge clk);
      a_start = 1'b0;
      wait_a(cyc);
      n_cmp++; if (a_map !== 64'hFFFF_FFC7_C7C7_FFFF) begin n_bad++;
         $display("FAIL ignore_map got %h want ffffffc7c7c7ffff", a_map); end
      n_cmp++; if (a_placed !== 7'd55) begin n_bad++;
         $display("FAIL ignore_placed got %0d want 55", a_placed); end
   endtask

   task automatic test_abort;
      go_a(3, 4, 1, 55);
      repeat (14) @(negedge clk);
      n_cmp++; if (a_busy !== 1'b1) begin n_bad++;
         $display("FAIL abort_busy_before got %b want 1", a_busy); end
      a_abort = 1'b1;
      @(negedge clk);
      a_abort = 1'b0;
      n_cmp++; if ({a_busy, a_done, a_err} !== 3'b000) begin n_bad++;
         $display("FAIL abort_flags got %b want 000", {a_busy, a_done, a_err}); end
      n_cmp++; if ({a_map, a_placed} !== 71'h0) begin n_bad++;
         $display("FAIL abort_map got %h want 0", {a_map, a_placed}); end
      a_abort = 1'b1; a_start = 1'b1;
      @(negedge clk);
      a_abort = 1'b0; a_start = 1'b0;
      @(negedge clk);
      n_cmp++; if (a_busy !== 1'b0) begin n_bad++;
         $display("FAIL abort_over_start got %b want 0", a_busy); end
   endtask

   task automatic test_rst_mid_safe;
      int cyc;
      go_a(0, 0, 1, 10);
      @(negedge clk);
      #1 rst = 1'b1;
      #1;
      n_cmp++; if ({a_busy, a_done, a_err, a_placed, a_map} !== 74'h0) begin
         n_bad++;
         $display("FAIL rst_mid_safe got %h want 0",
                  {a_busy, a_done, a_err, a_placed, a_map}); end
      @(negedge clk);
      rst = 1'b0;
      go_a(0, 0, 0, 5);
      wait_a(cyc);
      n_cmp++; if ({a_done, a_placed, a_map[0]} !== {1'b1, 7'd5, 1'b0}
                   || $countones(a_map) !== 5) begin n_bad++;
         $display("FAIL rst_recover got %h placed %0d want 5 mines", a_map, a_placed); end
   endtask

   task automatic test_small_board;
      int cyc;
      go_b(4, 6, 0, 34);
      wait_b(cyc);
      n_cmp++; if ({b_done, b_err, b_placed} !== {2'b10, 6'd34}) begin n_bad++;
         $display("FAIL small_done got %h want %h",
                  {b_done, b_err, b_placed}, {2'b10, 6'd34}); end
      n_cmp++; if (b_map !== 35'h3_FFFF_FFFF) begin n_bad++;
         $display("FAIL small_map got %h want 3ffffffff", b_map); end
      go_b(1, 1, 1, 0);
      wait_b(cyc);
      n_cmp++; if ({b_done, b_err, b_placed, b_map} !== {2'b10, 41'h0}) begin
         n_bad++;
         $display("FAIL zero_mines got %h want done only",
                  {b_done, b_err, b_placed, b_map}); end
      n_cmp++; if ((cyc >= 11) !== 1'b1) begin n_bad++;
         $display("FAIL zero_latency got %0d want >=11", cyc); end
      go_b(5, 0, 0, 1);
      wait_b(cyc);
      n_cmp++; if ({b_done, b_err, b_map} !== {2'b11, 35'h0}) begin n_bad++;
         $display("FAIL row_range got %h want err", {b_done, b_err, b_map}); end
      go_b(0, 7, 1, 1);
      wait_b(cyc);
      n_cmp++; if ({b_done, b_err, b_map} !== {2'b11, 35'h0}) begin n_bad++;
         $display("FAIL col_range got %h want err", {b_done, b_err, b_map}); end
   endtask

   initial begin
      test_reset;
      test_corner;
      test_restart;
      test_full_board;
      test_capacity;
      test_start_ignored;
      test_abort;
      test_rst_mid_safe;
      test_small_board;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
